mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Parametrised successor to the core's memory management unit: accepts one load/store per transaction from the CPU over a valid/ready request and a single-cycle response pulse. It decodes the address into the ROM or RAM region and drives per-device synchronous word ports with byte enables. Byte/half/word accesses at any byte offset are supported; accesses straddling a word boundary are split into two device beats. Unmapped addresses and ROM writes return a fault and are never forwarded to a device.

## Interface
- `SEL_WIDTH`, 8: upper address bits used for region select.
- `ROM_SELECT`, 8'h00: select value of the ROM region.
- `RAM_SELECT`, 8'h01: select value of the RAM region.
- `ROM_ADDR_WIDTH`, 8: ROM word-address width.
- `RAM_ADDR_WIDTH`, 8: RAM word-address width.

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit idle and able to accept.
- `req_we`  in  1  1 = store, 0 = load.
- `req_signed`  in  1  sign-extend load result.
- `req_size`  in  2  0 = byte, 1 = half, 3 = word, 2 = illegal.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, LSB-aligned.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  load result; 0 for stores and faults.
- `resp_fault`  out  1  access rejected.
- `rom_re`  out  1  ROM read strobe.
- `rom_addr`  out  ROM_ADDR_WIDTH  ROM word address.
- `rom_rdata`  in  32  ROM data, valid the cycle after `rom_re`.
- `ram_re`  out  1  RAM read strobe.
- `ram_we`  out  1  RAM write strobe.
- `ram_be`  out  4  RAM byte enables; `ram_be[i]` covers bits 8i+7:8i.
- `ram_addr`  out  RAM_ADDR_WIDTH  RAM word address.
- `ram_wdata`  out  32  RAM write data.
- `ram_rdata`  in  32  RAM data, valid the cycle after `ram_re`.

## Operation
- Request is accepted on a rising edge where `req_valid & req_ready`. All request fields are latched; the inputs are don't-care afterwards.
- Region decode on `addr[31:32-SEL_WIDTH]`. No match, `req_size == 2`, or a store to ROM causes a fault.
- Byte count n = 1/2/4. off = `addr[1:0]`. Mask m[7:0] = ((1<<n)-1) << off. W0 = `addr[.. :2]` truncated to the device width. W1 = W0+1, wrapping modulo the device depth.
- Split iff m[7:4] != 0.
- Beat 0 uses be = m[3:0]; beat 1 uses be = m[7:4].
- Store data: D = {32'b0, wdata} << 8·off. Beat 0 writes D[31:0]; beat 1 writes D[63:32]. There is no read-modify-write; byte enables are used instead.
- Load: R = ({d1, d0} >> 8·off), masked to n bytes. If `req_signed`, sign-extend from bit 8n-1. d1 = 0 when not split.
- Both beats always target the region decoded from the start address.
- FSM states:
  - IDLE → BEAT0 on accept; IDLE → RESP on accept with fault.
  - BEAT0 → BEAT1 if split; otherwise → WAIT for loads, → RESP for stores.
  - BEAT1 → WAIT for loads, → RESP for stores.
  - WAIT → RESP.
  - RESP → IDLE.
- Device strobes are asserted only in BEAT0/BEAT1 (combinational from state and latched request). The address is W0 in BEAT0 and W1 in BEAT1.
- Read data is captured on the edge ending the cycle after each read beat: d0 at the end of BEAT1 or WAIT, d1 at the end of WAIT.

## Timing
- Reset values: `req_ready`=0 while `reset_n`=0 (it is 1 in IDLE thereafter). `resp_valid`=0, `resp_rdata`=0, `resp_fault`=0, all strobes 0, `ram_be`=0, addresses 0, `ram_wdata`=0, FSM state IDLE.
- `req_ready` = 1 only in IDLE. There is at most one outstanding transaction.
- Latency, counted from the accept edge to the cycle in which `resp_valid`=1:
  - Fault: 1.
  - Aligned store: 2.
  - Split store: 3.
  - Aligned load: 3.
  - Split load: 4.
- `resp_rdata` and `resp_fault` are valid only while `resp_valid`=1 and hold until the next response.
- Back-to-back: a new request can be accepted at the edge ending RESP+1 (IDLE). Throughput is therefore one access per latency+1 cycles.
- Async reset mid-transaction aborts it with no response. Strobes drop immediately; a partially completed split store leaves beat 0 committed.

## Configuration
- `MEM_ACCESS_STRICT_ALIGN_EN`: when defined, any request where off is not a multiple of n faults (latency 1, no device access), and BEAT1 is never entered.
- When undefined, misaligned accesses are split as described above.

## Test plan
- Load word at 0x01000004, RAM word 1 = 0xDEADBEEF → `ram_re`, `ram_addr`=1 in BEAT0; response at accept+3 with `resp_rdata`=0xDEADBEEF, `resp_fault`=0.
- Store half 0xABCD at 0x01000003 → BEAT0: `ram_addr`=0, `ram_be`=4'b1000, `ram_wdata`[31:24]=0xCD. BEAT1: `ram_addr`=1, `ram_be`=4'b0001, `ram_wdata`[7:0]=0xAB. Response at accept+3 (macro on: fault at accept+1, no `ram_we`).
- Signed byte load at 0x00000006, ROM word 1 = 0x0080FF00 → `resp_rdata`=0xFFFFFF80. The same load unsigned → 0x00000080.
- Split word load at 0x010003FE, RAM depth 256, word 255 = 0x11223344, word 0 = 0x55667788 → second beat `ram_addr`=0 (wrap), `resp_rdata`=0x77881122 at accept+4.
- Store to 0x00000010, load from 0x02000000, and `req_size`=2 → each gives `resp_fault`=1 at accept+1, no strobes, `resp_rdata`=0.
- Assert `reset_n`=0 during BEAT1 of a split store → strobes drop the same cycle, no `resp_valid`, `req_ready`=1 after release.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit: decodes the ROM/RAM region and splits word-straddling accesses into two beats.
// Build option MEM_ACCESS_STRICT_ALIGN_EN: misaligned accesses fault instead of being split.
//
// state  | meaning
// IDLE   | ready, waiting for a request
// BEAT0  | first device beat at word W0
// BEAT1  | second device beat at word W1 (straddling access only)
// WAIT   | read data of the last read beat returns
// RESP   | one-cycle response pulse
module mem_access_unit #(
   parameter int                   SEL_WIDTH      = 8,
   parameter logic [SEL_WIDTH-1:0] ROM_SELECT     = SEL_WIDTH'(8'h00),
   parameter logic [SEL_WIDTH-1:0] RAM_SELECT     = SEL_WIDTH'(8'h01),
   parameter int                   ROM_ADDR_WIDTH = 8,
   parameter int                   RAM_ADDR_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_we,
   input  logic                      req_signed,
   input  logic [1:0]                req_size,
   input  logic [31:0]               req_addr,
   input  logic [31:0]               req_wdata,
   output logic                      resp_valid,
   output logic [31:0]               resp_rdata,
   output logic                      resp_fault,
   output logic                      rom_re,
   output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
   input  logic [31:0]               rom_rdata,
   output logic                      ram_re,
   output logic                      ram_we,
   output logic [3:0]                ram_be,
   output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
   output logic [31:0]               ram_wdata,
   input  logic [31:0]               ram_rdata
);

   typedef enum logic [2:0] {S_IDLE, S_BEAT0, S_BEAT1, S_WAIT, S_RESP} state_t;

   state_t                    r_state;
   logic                      r_we;
   logic                      r_signed;
   logic                      r_is_rom;
   logic                      r_split;
   logic [1:0]                r_size;
   logic [1:0]                r_off;
   logic [7:0]                r_mask;
   logic [31:0]               r_wdata;
   logic [31:0]               r_d0;
   logic [ROM_ADDR_WIDTH-1:0] r_rom_w0;
   logic [RAM_ADDR_WIDTH-1:0] r_ram_w0;
   logic                      r_resp_valid;
   logic                      r_resp_fault;
   logic [31:0]               r_resp_rdata;

   logic [SEL_WIDTH-1:0] w_sel;
   logic                 w_hit_rom;
   logic                 w_hit_ram;
   logic                 w_fault;
   logic                 w_accept;
   logic [7:0]           w_mask_base;
   logic [7:0]           w_mask;

   assign w_sel     = req_addr[31:32-SEL_WIDTH];
   assign w_hit_rom = (w_sel == ROM_SELECT);
   assign w_hit_ram = (w_sel == RAM_SELECT) & ~w_hit_rom;

   always_comb begin
      case (req_size)
         2'd0:    w_mask_base = 8'h01;
         2'd1:    w_mask_base = 8'h03;
         2'd3:    w_mask_base = 8'h0f;
         default: w_mask_base = 8'h00;
      endcase
   end

   assign w_mask = w_mask_base << req_addr[1:0];

`ifdef MEM_ACCESS_STRICT_ALIGN_EN
   logic w_misalign;
   assign w_misalign = ((req_size == 2'd1) & req_addr[0]) |
                       ((req_size == 2'd3) & (req_addr[1:0] != 2'd0));
   assign w_fault = (req_size == 2'd2) | ~(w_hit_rom | w_hit_ram) |
                    (w_hit_rom & req_we) | w_misalign;
`else
   assign w_fault = (req_size == 2'd2) | ~(w_hit_rom | w_hit_ram) |
                    (w_hit_rom & req_we);
`endif

   assign w_accept = req_valid & req_ready;

   // Load assembly: the second beat's data arrives live in WAIT, the first was captured in BEAT1.
   logic [31:0] w_dev_rdata;
   logic [31:0] w_lo;
   logic [31:0] w_hi;
   logic [63:0] w_rshift;
   logic [31:0] w_raw;
   logic [31:0] w_load;
   logic [63:0] w_wshift;

   assign w_dev_rdata = r_is_rom ? rom_rdata : ram_rdata;
   assign w_lo        = r_split ? r_d0 : w_dev_rdata;
   assign w_hi        = r_split ? w_dev_rdata : 32'd0;
   assign w_rshift    = {w_hi, w_lo} >> {r_off, 3'b000};
   assign w_raw       = w_rshift[31:0];
   assign w_wshift    = {32'd0, r_wdata} << {r_off, 3'b000};

   always_comb begin
      case (r_size)
         2'd0:    w_load = {{24{r_signed & w_raw[7]}}, w_raw[7:0]};
         2'd1:    w_load = {{16{r_signed & w_raw[15]}}, w_raw[15:0]};
         default: w_load = w_raw;
      endcase
   end

   logic w_beat;
   logic w_beat1;
   logic w_ram_beat;

   assign w_beat1    = (r_state == S_BEAT1);
   assign w_beat     = (r_state == S_BEAT0) | w_beat1;
   assign w_ram_beat = w_beat & ~r_is_rom;

   assign req_ready = (r_state == S_IDLE) & reset_n;
   assign rom_re    = w_beat & r_is_rom;
   assign rom_addr  = rom_re ? (w_beat1 ? r_rom_w0 + ROM_ADDR_WIDTH'(1) : r_rom_w0) : '0;
   assign ram_re    = w_ram_beat & ~r_we;
   assign ram_we    = w_ram_beat & r_we;
   assign ram_be    = w_ram_beat ? (w_beat1 ? r_mask[7:4] : r_mask[3:0]) : 4'd0;
   assign ram_addr  = w_ram_beat ? (w_beat1 ? r_ram_w0 + RAM_ADDR_WIDTH'(1) : r_ram_w0) : '0;
   assign ram_wdata = ram_we ? (w_beat1 ? w_wshift[63:32] : w_wshift[31:0]) : 32'd0;

   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_resp_rdata;
   assign resp_fault = r_resp_fault;

   logic w_unused;
   assign w_unused = ^{req_addr, w_rshift[63:32]};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_we         <= 1'b0;
         r_signed     <= 1'b0;
         r_is_rom     <= 1'b0;
         r_split      <= 1'b0;
         r_size       <= 2'd0;
         r_off        <= 2'd0;
         r_mask       <= 8'd0;
         r_wdata      <= 32'd0;
         r_d0         <= 32'd0;
         r_rom_w0     <= '0;
         r_ram_w0     <= '0;
         r_resp_valid <= 1'b0;
         r_resp_fault <= 1'b0;
         r_resp_rdata <= 32'd0;
      end else begin
         r_resp_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_we     <= req_we;
                  r_signed <= req_signed;
                  r_is_rom <= w_hit_rom;
                  r_split  <= |w_mask[7:4];
                  r_size   <= req_size;
                  r_off    <= req_addr[1:0];
                  r_mask   <= w_mask;
                  r_wdata  <= req_wdata;
                  r_rom_w0 <= req_addr[ROM_ADDR_WIDTH+1:2];
                  r_ram_w0 <= req_addr[RAM_ADDR_WIDTH+1:2];
                  if (w_fault) begin
                     r_state      <= S_RESP;
                     r_resp_valid <= 1'b1;
                     r_resp_fault <= 1'b1;
                     r_resp_rdata <= 32'd0;
                  end else begin
                     r_state <= S_BEAT0;
                  end
               end
            end
            S_BEAT0: begin
               if (r_split) begin
                  r_state <= S_BEAT1;
               end else if (r_we) begin
                  r_state      <= S_RESP;
                  r_resp_valid <= 1'b1;
                  r_resp_fault <= 1'b0;
                  r_resp_rdata <= 32'd0;
               end else begin
                  r_state <= S_WAIT;
               end
            end
            S_BEAT1: begin
               r_d0 <= w_dev_rdata;
               if (r_we) begin
                  r_state      <= S_RESP;
                  r_resp_valid <= 1'b1;
                  r_resp_fault <= 1'b0;
                  r_resp_rdata <= 32'd0;
               end else begin
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               r_state      <= S_RESP;
               r_resp_valid <= 1'b1;
               r_resp_fault <= 1'b0;
               r_resp_rdata <= w_load;
            end
            S_RESP: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: byte-level reference model, behavioural ROM/RAM devices.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid, req_ready, req_we, req_signed;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_fault;
   logic [31:0] resp_rdata;
   logic        rom_re, ram_re, ram_we;
   logic [7:0]  rom_addr, ram_addr;
   logic [3:0]  ram_be;
   logic [31:0] rom_rdata, ram_rdata, ram_wdata;

   always #5 clk = ~clk;

   mem_access_unit dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_signed (req_signed),
      .req_size   (req_size),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_fault (resp_fault),
      .rom_re     (rom_re),
      .rom_addr   (rom_addr),
      .rom_rdata  (rom_rdata),
      .ram_re     (ram_re),
      .ram_we     (ram_we),
      .ram_be     (ram_be),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata)
   );

   logic [31:0] rom_mem [0:255];
   logic [31:0] ram_mem [0:255];
   logic [31:0] sh_ram  [0:255];
   logic [31:0] wr_tmp;

   always @(posedge clk) begin
      if (rom_re) rom_rdata <= rom_mem[rom_addr];
      if (ram_re) ram_rdata <= ram_mem[ram_addr];
      if (ram_we) begin
         wr_tmp = ram_mem[ram_addr];
         for (int b = 0; b < 4; b++)
            if (ram_be[b]) wr_tmp[8*b +: 8] = ram_wdata[8*b +: 8];
         ram_mem[ram_addr] <= wr_tmp;
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected outcome of one access
   logic        e_fault;
   logic [31:0] e_rdata;
   int          e_lat, e_beats;
   logic [2:0]  e_kind;
   int          e_addr [2];
   logic [3:0]  e_be [2];

   task automatic model(input logic we, input logic sgn, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata);
      int n, off, k, w, lane;
      logic [63:0] v;
      logic is_rom, is_ram;
      n      = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      off    = int'(addr[1:0]);
      is_rom = (addr[31:24] == 8'h00);
      is_ram = (addr[31:24] == 8'h01);
      e_fault = (size == 2'd2) || !(is_rom || is_ram) || (is_rom && we);
`ifdef MEM_ACCESS_STRICT_ALIGN_EN
      if (off % n != 0) e_fault = 1'b1;
`endif
      e_rdata = 32'd0;
      e_be[0] = 4'd0;
      e_be[1] = 4'd0;
      e_kind  = 3'd0;
      if (e_fault) begin
         e_lat   = 1;
         e_beats = 0;
         return;
      end
      e_beats   = (off + n > 4) ? 2 : 1;
      e_lat     = (we ? 2 : 3) + e_beats - 1;
      e_kind    = {is_rom, is_ram & ~we, is_ram & we};
      e_addr[0] = int'(addr >> 2) & 255;
      e_addr[1] = (int'(addr >> 2) + 1) & 255;
      v = 64'd0;
      for (int i = 0; i < n; i++) begin
         k    = off + i;
         w    = e_addr[k / 4];
         lane = k % 4;
         e_be[k / 4][lane] = 1'b1;
         if (we) sh_ram[w][8*lane +: 8] = wdata[8*i +: 8];
         else if (is_rom) v[8*i +: 8] = rom_mem[w][8*lane +: 8];
         else v[8*i +: 8] = sh_ram[w][8*lane +: 8];
      end
      if (!we && sgn && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
      e_rdata = v[31:0];
   endtask

   // Observed beats and response of the last access
   logic [31:0] b_addr [2];
   logic [3:0]  b_be   [2];
   logic [31:0] b_wd   [2];
   logic [2:0]  b_kind [2];
   logic [31:0] g_rdata;
   logic        g_fault;

   task automatic xact(input logic we, input logic sgn, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
      int lat, nb;
      bit got;
      model(we, sgn, size, addr, wdata);
      @(negedge clk);
      chk("ready_idle", {31'd0, req_ready}, 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_signed = sgn;
      req_size   = size;
      req_addr   = addr;
      req_wdata  = wdata;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_we     = 1'($urandom);
      req_signed = 1'($urandom);
      req_size   = 2'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      lat = 0; nb = 0; got = 0;
      g_rdata = 32'd0; g_fault = 1'b0;
      while (!got && lat < 8) begin
         @(negedge clk);
         lat++;
         if (rom_re | ram_re | ram_we) begin
            if (nb < 2) begin
               b_addr[nb] = rom_re ? {24'd0, rom_addr} : {24'd0, ram_addr};
               b_be[nb]   = ram_be;
               b_wd[nb]   = ram_wdata;
               b_kind[nb] = {rom_re, ram_re, ram_we};
            end
            nb++;
         end
         if (resp_valid) begin
            got     = 1;
            g_rdata = resp_rdata;
            g_fault = resp_fault;
         end
      end
      chk("resp_seen", {31'd0, got}, 32'd1);
      chk("latency", lat, e_lat);
      chk("fault", {31'd0, g_fault}, {31'd0, e_fault});
      chk("rdata", g_rdata, e_rdata);
      chk("beats", nb, e_beats);
      for (int i = 0; i < 2; i++) begin
         if (i < nb && i < e_beats) begin
            chk("beat_kind", {29'd0, b_kind[i]}, {29'd0, e_kind});
            chk("beat_addr", b_addr[i], e_addr[i]);
            if (!e_kind[2]) chk("beat_be", {28'd0, b_be[i]}, {28'd0, e_be[i]});
         end
      end
      @(negedge clk);
      chk("resp_drop", {31'd0, resp_valid}, 32'd0);
   endtask

   initial begin
      logic [7:0]  sel;
      logic [31:0] lo;
      int r;
      for (int i = 0; i < 256; i++) rom_mem[i] = $urandom;
      rom_mem[1] = 32'h0080FF00;
      reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_signed = 1'b0;
      req_size = 2'd0; req_addr = 32'd0; req_wdata = 32'd0;

      repeat (3) @(negedge clk);
      chk("rst_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_resp", {29'd0, resp_valid, resp_fault, |resp_rdata}, 32'd0);
      chk("rst_strobes", {28'd0, rom_re, ram_re, ram_we, |ram_be}, 32'd0);
      chk("rst_addr", {16'd0, rom_addr, ram_addr}, 32'd0);
      chk("rst_wdata", ram_wdata, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

      for (int i = 0; i < 256; i++) xact(1'b1, 1'b0, 2'd3, 32'h0100_0000 | (i << 2), $urandom);

      xact(1'b1, 1'b0, 2'd3, 32'h0100_0004, 32'hDEADBEEF);
      xact(1'b0, 1'b0, 2'd3, 32'h0100_0004, 32'd0);
      chk("ld_word", g_rdata, 32'hDEADBEEF);

      xact(1'b1, 1'b0, 2'd1, 32'h0100_0003, 32'h0000ABCD);
`ifndef MEM_ACCESS_STRICT_ALIGN_EN
      chk("st_half_b0_wd", {24'd0, b_wd[0][31:24]}, 32'h0000_00CD);
      chk("st_half_b1_wd", {24'd0, b_wd[1][7:0]}, 32'h0000_00AB);
`endif

      xact(1'b0, 1'b1, 2'd0, 32'h0000_0006, 32'd0);
      chk("ld_sbyte", g_rdata, 32'hFFFFFF80);
      xact(1'b0, 1'b0, 2'd0, 32'h0000_0006, 32'd0);
      chk("ld_ubyte", g_rdata, 32'h0000_0080);

      xact(1'b1, 1'b0, 2'd3, 32'h0100_03FC, 32'h11223344);
      xact(1'b1, 1'b0, 2'd3, 32'h0100_0000, 32'h55667788);
      xact(1'b0, 1'b0, 2'd3, 32'h0100_03FE, 32'd0);
`ifndef MEM_ACCESS_STRICT_ALIGN_EN
      chk("split_ld_data", g_rdata, 32'h77881122);
`endif

      xact(1'b1, 1'b0, 2'd3, 32'h0000_0010, 32'h12345678);
      xact(1'b0, 1'b0, 2'd3, 32'h0200_0000, 32'd0);
      xact(1'b0, 1'b0, 2'd2, 32'h0100_0008, 32'd0);

      for (int t = 0; t < 300; t++) begin
         r   = $urandom_range(0, 9);
         sel = (r < 4) ? 8'h00 : (r < 8) ? 8'h01 : 8'($urandom_range(2, 255));
         lo  = $urandom;
         if ($urandom_range(0, 3) == 0) lo[9:2] = 8'hFF;
         xact(1'($urandom), 1'($urandom), 2'($urandom), {sel, lo[23:0]}, $urandom);
      end

      // Reset in the middle of a store: strobes must drop at once and no response follows.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_signed = 1'b0;
`ifdef MEM_ACCESS_STRICT_ALIGN_EN
      req_size = 2'd3; req_addr = 32'h0100_0008; req_wdata = 32'hCAFEF00D;
`else
      req_size = 2'd1; req_addr = 32'h0100_0003; req_wdata = 32'h0000_1357;
`endif
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
`ifndef MEM_ACCESS_STRICT_ALIGN_EN
      @(negedge clk);
      sh_ram[0][31:24] = 8'h57;
`endif
      chk("mid_we_before", {31'd0, ram_we}, 32'd1);
      reset_n = 1'b0;
      #1;
      chk("mid_strobes", {29'd0, rom_re, ram_re, ram_we}, 32'd0);
      chk("mid_ready", {31'd0, req_ready}, 32'd0);
      repeat (3) begin
         @(negedge clk);
         chk("mid_no_resp", {31'd0, resp_valid}, 32'd0);
      end
      reset_n = 1'b1;
      #1;
      chk("mid_ready_after", {31'd0, req_ready}, 32'd1);
      xact(1'b0, 1'b0, 2'd3, 32'h0100_0000, 32'd0);
      xact(1'b0, 1'b0, 2'd3, 32'h0100_0004, 32'd0);

      @(negedge clk);
      for (int i = 0; i < 256; i++) chk("ram_word", ram_mem[i], sh_ram[i]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
